// File: rtl/qmem_sram_ctrl.sv
// QMEM 32-bit slave bridging to an asynchronous 16-bit SRAM.
// Each word access is split into up to two strobed half-accesses, low half first.
module qmem_sram_ctrl #(
    parameter int unsigned QAW = 32,
    parameter int unsigned QDW = 32,
    parameter int unsigned QSW = QDW/8,
    parameter int unsigned SAW = 18,
    parameter int unsigned WS  = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cs,
    input  logic           we,
    input  logic [QSW-1:0] sel,
    input  logic [QAW-1:0] adr,
    input  logic [QDW-1:0] dat_w,
    output logic [QDW-1:0] dat_r,
    output logic           ack,
    output logic           err,
    output logic [SAW-1:0] sram_adr,
    output logic [15:0]    sram_dat_w,
    output logic           sram_dat_oe,
    input  logic [15:0]    sram_dat_r,
    output logic           sram_ce_n,
    output logic           sram_oe_n,
    output logic           sram_we_n,
    output logic           sram_ub_n,
    output logic           sram_lb_n
);

    localparam int unsigned PW = $clog2(WS + 3);
    localparam logic [PW-1:0] PH_STB_LAST = PW'(WS + 1);
    localparam logic [PW-1:0] PH_HOLD     = PW'(WS + 2);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_ACK  = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    state_t          r_state, w_nxt_state;
    logic [PW-1:0]   r_phase, w_nxt_phase;

    logic            r_we;
    logic [QSW-1:0]  r_sel;
    logic [SAW-2:0]  r_wadr;
    logic [QDW-1:0]  r_dat;

    logic [QDW-1:0]  r_dat_r;
    logic            r_ack, r_err;
    logic [SAW-1:0]  r_sram_adr;
    logic [15:0]     r_sram_dat_w;
    logic            r_sram_dat_oe;
    logic            r_ce_n, r_oe_n, r_we_n, r_ub_n, r_lb_n;

    logic            w_accept;
    logic            w_req_we;
    logic [QSW-1:0]  w_req_sel;
    logic [SAW-2:0]  w_req_wadr;
    logic [QDW-1:0]  w_req_dat;
    logic            w_in_lo, w_in_hi, w_half, w_strobe;
    logic [QDW-1:0]  w_nxt_dat_r;
    logic [SAW-1:0]  w_nxt_sram_adr;
    logic [15:0]     w_nxt_sram_dat_w;
    logic            w_nxt_ub_n, w_nxt_lb_n;

    // Byte offset within the word carries no meaning for a 32-bit slave.
    logic            w_unused_adr;
    assign w_unused_adr = &{1'b0, adr[1:0]};

    // Next state, phase and the output values for the coming cycle.
    always_comb begin
        w_req_we    = r_we;
        w_req_sel   = r_sel;
        w_req_wadr  = r_wadr;
        w_req_dat   = r_dat;
        w_nxt_state = r_state;
        w_nxt_phase = '0;
        w_accept    = 1'b0;

        // In IDLE the request is taken straight from the bus so setup starts next cycle.
        if (r_state == ST_IDLE) begin
            w_req_we   = we;
            w_req_sel  = sel;
            w_req_wadr = adr[SAW:2];
            w_req_dat  = dat_w;
        end

        unique case (r_state)
            ST_IDLE: begin
                if (cs) begin
                    w_accept = 1'b1;
                    if (|adr[QAW-1:SAW+1])  w_nxt_state = ST_ERR;
                    else if (|sel[1:0])     w_nxt_state = ST_LO;
                    else if (|sel[3:2])     w_nxt_state = ST_HI;
                    else                    w_nxt_state = ST_ACK;
                end
            end
            ST_LO: begin
                if (r_phase == PH_HOLD) w_nxt_state = (|r_sel[3:2]) ? ST_HI : ST_ACK;
                else                    w_nxt_phase = r_phase + PW'(1);
            end
            ST_HI: begin
                if (r_phase == PH_HOLD) w_nxt_state = ST_ACK;
                else                    w_nxt_phase = r_phase + PW'(1);
            end
            default: w_nxt_state = ST_IDLE;
        endcase

        w_in_lo  = (w_nxt_state == ST_LO);
        w_in_hi  = (w_nxt_state == ST_HI);
        w_half   = w_in_lo | w_in_hi;
        w_strobe = w_half && (w_nxt_phase != '0) && (w_nxt_phase <= PH_STB_LAST);

        w_nxt_ub_n       = 1'b1;
        w_nxt_lb_n       = 1'b1;
        w_nxt_sram_adr   = r_sram_adr;
        w_nxt_sram_dat_w = r_sram_dat_w;
        if (w_in_lo) begin
            w_nxt_ub_n       = ~w_req_sel[1];
            w_nxt_lb_n       = ~w_req_sel[0];
            w_nxt_sram_adr   = {w_req_wadr, 1'b0};
            w_nxt_sram_dat_w = w_req_dat[15:0];
        end else if (w_in_hi) begin
            w_nxt_ub_n       = ~w_req_sel[3];
            w_nxt_lb_n       = ~w_req_sel[2];
            w_nxt_sram_adr   = {w_req_wadr, 1'b1};
            w_nxt_sram_dat_w = w_req_dat[31:16];
        end

        // Read data: cleared on accept, each half loaded at the end of its last strobe.
        w_nxt_dat_r = r_dat_r;
        if (w_accept && !we) w_nxt_dat_r = '0;
        if (!r_we && (r_phase == PH_STB_LAST)) begin
            if (r_state == ST_LO)      w_nxt_dat_r[15:0]  = sram_dat_r;
            else if (r_state == ST_HI) w_nxt_dat_r[31:16] = sram_dat_r;
        end
    end

    // State, latched request and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_phase       <= '0;
            r_we          <= 1'b0;
            r_sel         <= '0;
            r_wadr        <= '0;
            r_dat         <= '0;
            r_dat_r       <= '0;
            r_ack         <= 1'b0;
            r_err         <= 1'b0;
            r_sram_adr    <= '0;
            r_sram_dat_w  <= '0;
            r_sram_dat_oe <= 1'b0;
            r_ce_n        <= 1'b1;
            r_oe_n        <= 1'b1;
            r_we_n        <= 1'b1;
            r_ub_n        <= 1'b1;
            r_lb_n        <= 1'b1;
        end else begin
            r_state       <= w_nxt_state;
            r_phase       <= w_nxt_phase;
            if (w_accept) begin
                r_we   <= we;
                r_sel  <= sel;
                r_wadr <= adr[SAW:2];
                r_dat  <= dat_w;
            end
            r_dat_r       <= w_nxt_dat_r;
            r_ack         <= (w_nxt_state == ST_ACK);
            r_err         <= (w_nxt_state == ST_ERR);
            r_sram_adr    <= w_nxt_sram_adr;
            r_sram_dat_w  <= w_nxt_sram_dat_w;
            r_sram_dat_oe <= w_half & w_req_we;
            r_ce_n        <= ~w_half;
            r_oe_n        <= ~(w_strobe & ~w_req_we);
            r_we_n        <= ~(w_strobe & w_req_we);
            r_ub_n        <= w_nxt_ub_n;
            r_lb_n        <= w_nxt_lb_n;
        end
    end

    assign dat_r       = r_dat_r;
    assign ack         = r_ack;
    assign err         = r_err;
    assign sram_adr    = r_sram_adr;
    assign sram_dat_w  = r_sram_dat_w;
    assign sram_dat_oe = r_sram_dat_oe;
    assign sram_ce_n   = r_ce_n;
    assign sram_oe_n   = r_oe_n;
    assign sram_we_n   = r_we_n;
    assign sram_ub_n   = r_ub_n;
    assign sram_lb_n   = r_lb_n;

endmodule

// File: tb/tb_qmem_sram_ctrl.sv
// Bench for qmem_sram_ctrl: directed and random QMEM accesses against a byte-addressed
// reference memory, with a behavioural 16-bit SRAM attached to the DUT.
module tb_qmem_sram_ctrl;

    localparam int unsigned WS       = 1;
    localparam int          HALF_CYC = WS + 3;
    localparam int          STB_CYC  = WS + 1;

    logic        clk = 1'b0;
    logic        rst, cs, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w, dat_r;
    logic        ack, err;
    logic [17:0] sram_adr;
    logic [15:0] sram_dat_w, sram_dat_r;
    logic        sram_dat_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    int total = 0;
    int bad   = 0;

    logic [15:0] sram_mem [int];
    logic [7:0]  ref_bytes [int];

    int          obs_lat, obs_nwe, obs_noe, obs_nce;
    logic        obs_ack, obs_err, obs_oebad, obs_both;
    logic [1:0]  obs_be_lo, obs_be_hi;
    logic [31:0] obs_rdata;

    always #5 clk = ~clk;

    qmem_sram_ctrl #(.QAW(32), .QDW(32), .QSW(4), .SAW(18), .WS(WS)) dut (
        .clk(clk), .rst(rst), .cs(cs), .we(we), .sel(sel), .adr(adr),
        .dat_w(dat_w), .dat_r(dat_r), .ack(ack), .err(err),
        .sram_adr(sram_adr), .sram_dat_w(sram_dat_w), .sram_dat_oe(sram_dat_oe),
        .sram_dat_r(sram_dat_r), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    // Behavioural SRAM: byte-lane writes while strobed, read data presented mid-cycle.
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            logic [15:0] w;
            w = sram_mem.exists(int'(sram_adr)) ? sram_mem[int'(sram_adr)] : 16'h0000;
            if (!sram_lb_n) w[7:0]  = sram_dat_w[7:0];
            if (!sram_ub_n) w[15:8] = sram_dat_w[15:8];
            sram_mem[int'(sram_adr)] = w;
        end
    end

    always @(negedge clk) begin
        if (!sram_ce_n && !sram_oe_n)
            sram_dat_r <= sram_mem.exists(int'(sram_adr)) ? sram_mem[int'(sram_adr)] : 16'h0000;
        else
            sram_dat_r <= 16'h5A5A;
    end

    function automatic logic [15:0] sram_word(input int a);
        return sram_mem.exists(a) ? sram_mem[a] : 16'h0000;
    endfunction

    function automatic logic [7:0] ref_byte(input int k);
        return ref_bytes.exists(k) ? ref_bytes[k] : 8'h00;
    endfunction

    task automatic ref_write(input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_bytes[int'(a & 32'h0007_FFFC) + b] = d[8*b +: 8];
    endtask

    function automatic logic [31:0] ref_read(input logic [3:0] s, input logic [31:0] a);
        int base;
        logic [31:0] r;
        base = int'(a & 32'h0007_FFFC);
        r = 32'h0;
        if (s[1:0] != 2'b00) r[15:0]  = {ref_byte(base + 1), ref_byte(base)};
        if (s[3:2] != 2'b00) r[31:16] = {ref_byte(base + 3), ref_byte(base + 2)};
        return r;
    endfunction

    function automatic int halves(input logic [3:0] s);
        return ((s[1:0] != 2'b00) ? 1 : 0) + ((s[3:2] != 2'b00) ? 1 : 0);
    endfunction

    // Issues one access with a single-cycle cs and records what the bus and SRAM side did.
    task automatic do_access(input logic twe, input logic [3:0] tsel,
                             input logic [31:0] tadr, input logic [31:0] tdat);
        obs_lat = 0; obs_nwe = 0; obs_noe = 0; obs_nce = 0;
        obs_ack = 1'b0; obs_err = 1'b0; obs_oebad = 1'b0; obs_both = 1'b0;
        obs_be_lo = 2'b00; obs_be_hi = 2'b00;
        @(negedge clk);
        cs = 1'b1; we = twe; sel = tsel; adr = tadr; dat_w = tdat;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            cs = 1'b0;
            if (!sram_ce_n) obs_nce++;
            if (!sram_we_n) obs_nwe++;
            if (!sram_oe_n) obs_noe++;
            if (!sram_we_n || !sram_oe_n) begin
                if (sram_adr[0]) obs_be_hi = {~sram_ub_n, ~sram_lb_n};
                else             obs_be_lo = {~sram_ub_n, ~sram_lb_n};
            end
            if (sram_dat_oe !== (twe && !sram_ce_n)) obs_oebad = 1'b1;
            if (ack && err) obs_both = 1'b1;
            if (ack || err) begin
                obs_lat = n; obs_ack = ack; obs_err = err;
                break;
            end
        end
        @(negedge clk);
        obs_rdata = dat_r;
    endtask

    task automatic test_reset();
        rst = 1'b1; cs = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; dat_w = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({ack, err, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dat_oe} !== 8'b0011_1110) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=00111110",
                     {ack, err, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dat_oe});
        end
        total++;
        if (dat_r !== 32'h0) begin bad++; $display("FAIL reset_dat_r got=%h want=0", dat_r); end
        total++;
        if (sram_adr !== 18'h0 || sram_dat_w !== 16'h0) begin
            bad++; $display("FAIL reset_sram_bus got adr=%h dat=%h want 0", sram_adr, sram_dat_w);
        end
        rst = 1'b0;
    endtask

    task automatic test_write_word();
        do_access(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        ref_write(4'hF, 32'h10, 32'hDEAD_BEEF);
        total++;
        if (obs_lat !== 9 || obs_ack !== 1'b1 || obs_err !== 1'b0) begin
            bad++; $display("FAIL wr_word_lat got lat=%0d ack=%b err=%b want lat=9 ack=1", obs_lat, obs_ack, obs_err);
        end
        total++;
        if (obs_nwe !== 2 * STB_CYC || obs_noe !== 0) begin
            bad++; $display("FAIL wr_word_strobes got we=%0d oe=%0d want we=%0d oe=0", obs_nwe, obs_noe, 2 * STB_CYC);
        end
        total++;
        if (sram_word(8) !== 16'hBEEF || sram_word(9) !== 16'hDEAD) begin
            bad++; $display("FAIL wr_word_mem got w8=%h w9=%h want BEEF DEAD", sram_word(8), sram_word(9));
        end
        total++;
        if (obs_oebad !== 1'b0 || obs_be_lo !== 2'b11 || obs_be_hi !== 2'b11) begin
            bad++; $display("FAIL wr_word_lanes got oebad=%b lo=%b hi=%b want 0 11 11", obs_oebad, obs_be_lo, obs_be_hi);
        end
    endtask

    task automatic test_read_word();
        do_access(1'b0, 4'hF, 32'h10, 32'h0);
        total++;
        if (obs_rdata !== 32'hDEAD_BEEF || obs_lat !== 9) begin
            bad++; $display("FAIL rd_word got data=%h lat=%0d want DEADBEEF 9", obs_rdata, obs_lat);
        end
        total++;
        if (obs_noe !== 2 * STB_CYC || obs_nwe !== 0 || obs_oebad !== 1'b0) begin
            bad++; $display("FAIL rd_word_strobes got oe=%0d we=%0d oebad=%b want %0d 0 0",
                            obs_noe, obs_nwe, obs_oebad, 2 * STB_CYC);
        end
        repeat (3) @(negedge clk);
        total++;
        if (dat_r !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_hold_idle got=%h want DEADBEEF", dat_r); end
        do_access(1'b1, 4'hF, 32'h30, 32'h1234_5678);
        ref_write(4'hF, 32'h30, 32'h1234_5678);
        total++;
        if (obs_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_hold_write got=%h want DEADBEEF", obs_rdata); end
    endtask

    task automatic test_byte_write();
        do_access(1'b1, 4'b0100, 32'h10, 32'h00AA_0000);
        ref_write(4'b0100, 32'h10, 32'h00AA_0000);
        total++;
        if (obs_lat !== 5 || obs_nwe !== STB_CYC) begin
            bad++; $display("FAIL byte_wr_lat got lat=%0d we=%0d want 5 %0d", obs_lat, obs_nwe, STB_CYC);
        end
        total++;
        if (obs_be_hi !== 2'b01 || obs_be_lo !== 2'b00) begin
            bad++; $display("FAIL byte_wr_lanes got hi=%b lo=%b want 01 00", obs_be_hi, obs_be_lo);
        end
        total++;
        if (sram_word(9) !== 16'hDEAA || sram_word(8) !== 16'hBEEF) begin
            bad++; $display("FAIL byte_wr_mem got w9=%h w8=%h want DEAA BEEF", sram_word(9), sram_word(8));
        end
        do_access(1'b0, 4'hF, 32'h10, 32'h0);
        total++;
        if (obs_rdata !== 32'hDEAA_BEEF) begin bad++; $display("FAIL byte_rd got=%h want DEAABEEF", obs_rdata); end
    endtask

    task automatic test_err_and_empty();
        do_access(1'b1, 4'hF, 32'h0008_0000, 32'hFFFF_FFFF);
        total++;
        if (obs_err !== 1'b1 || obs_ack !== 1'b0 || obs_lat !== 1 || obs_both !== 1'b0) begin
            bad++; $display("FAIL err_resp got err=%b ack=%b lat=%0d want 1 0 1", obs_err, obs_ack, obs_lat);
        end
        total++;
        if (obs_nce !== 0) begin bad++; $display("FAIL err_no_ce got ce_cycles=%0d want 0", obs_nce); end
        do_access(1'b0, 4'h0, 32'h10, 32'h0);
        total++;
        if (obs_ack !== 1'b1 || obs_lat !== 1 || obs_nce !== 0) begin
            bad++; $display("FAIL sel0 got ack=%b lat=%0d ce=%0d want 1 1 0", obs_ack, obs_lat, obs_nce);
        end
        total++;
        if (obs_rdata !== 32'h0) begin bad++; $display("FAIL sel0_rd_clear got=%h want 0", obs_rdata); end
    endtask

    task automatic test_reset_mid();
        int spurious;
        @(negedge clk);
        cs = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h40; dat_w = 32'hCAFE_F00D;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            cs = 1'b0;
        end
        total++;
        if (sram_we_n !== 1'b0 || sram_adr !== 18'h21) begin
            bad++; $display("FAIL mid_hi_strobe got we_n=%b adr=%h want 0 21", sram_we_n, sram_adr);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, ack, err} !== 5'b11100) begin
            bad++; $display("FAIL mid_reset got ce/oe/we/ack/err=%b want 11100",
                            {sram_ce_n, sram_oe_n, sram_we_n, ack, err});
        end
        rst = 1'b0;
        spurious = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (ack || err || !sram_ce_n) spurious++;
        end
        total++;
        if (spurious !== 0) begin bad++; $display("FAIL mid_no_ack got=%0d want 0", spurious); end
        do_access(1'b1, 4'hF, 32'h40, 32'h0BAD_C0DE);
        ref_write(4'hF, 32'h40, 32'h0BAD_C0DE);
        do_access(1'b0, 4'hF, 32'h40, 32'h0);
        total++;
        if (obs_rdata !== 32'h0BAD_C0DE || obs_lat !== 9) begin
            bad++; $display("FAIL mid_recover got data=%h lat=%0d want 0BADC0DE 9", obs_rdata, obs_lat);
        end
    endtask

    task automatic test_back_to_back();
        int wrong, got;
        logic [31:0] td;
        @(negedge clk);
        cs = 1'b1; we = 1'b1; sel = 4'h0; adr = 32'h20; dat_w = 32'h0;
        wrong = 0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (ack !== ((n % 2) == 1)) wrong++;
        end
        cs = 1'b0;
        total++;
        if (wrong !== 0) begin bad++; $display("FAIL b2b_held_cs got misses=%0d want 0", wrong); end

        td = $urandom;
        @(negedge clk);
        cs = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h24; dat_w = td;
        got = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ack) begin got = k; break; end
        end
        ref_write(4'hF, 32'h24, td);
        we = 1'b0; dat_w = 32'h0;
        total++;
        if (got !== 9) begin bad++; $display("FAIL b2b_wr_lat got=%0d want 9", got); end
        got = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 2) cs = 1'b0;
            if (ack) begin got = k; break; end
        end
        cs = 1'b0;
        @(negedge clk);
        total++;
        if (got !== 10 || dat_r !== ref_read(4'hF, 32'h24)) begin
            bad++; $display("FAIL b2b_rd got lat=%0d data=%h want 10 %h", got, dat_r, ref_read(4'hF, 32'h24));
        end
    endtask

    task automatic test_random();
        logic        tw, oor, known;
        logic [3:0]  ts;
        logic [31:0] ta, td, last_rd, exp_rd;
        int          el, es;
        known = 1'b0; last_rd = 32'h0;
        for (int it = 0; it < 40; it++) begin
            tw = 1'($urandom_range(0, 1));
            ts = 4'($urandom);
            ta = ($urandom_range(0, 1) == 1 ? 32'h0007_FFC0 : 32'h0) + 32'($urandom_range(0, 15)) * 4
                 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) ta[int'($urandom_range(19, 31))] = 1'b1;
            td = $urandom;
            oor = (ta[31:19] != 13'h0);
            el = oor ? 1 : 1 + halves(ts) * HALF_CYC;
            es = oor ? 0 : halves(ts) * STB_CYC;
            exp_rd = ref_read(ts, ta);
            do_access(tw, ts, ta, td);
            total++;
            if (obs_lat !== el || obs_ack !== !oor || obs_err !== oor || obs_both !== 1'b0) begin
                bad++; $display("FAIL rnd_resp it=%0d got lat=%0d ack=%b err=%b want lat=%0d ack=%b err=%b",
                                it, obs_lat, obs_ack, obs_err, el, !oor, oor);
            end
            total++;
            if (obs_nwe !== (tw ? es : 0) || obs_noe !== (tw ? 0 : es) || obs_oebad !== 1'b0) begin
                bad++; $display("FAIL rnd_strobes it=%0d got we=%0d oe=%0d oebad=%b want we=%0d oe=%0d",
                                it, obs_nwe, obs_noe, obs_oebad, tw ? es : 0, tw ? 0 : es);
            end
            total++;
            if (obs_be_lo !== (oor ? 2'b00 : ts[1:0]) || obs_be_hi !== (oor ? 2'b00 : ts[3:2])) begin
                bad++; $display("FAIL rnd_lanes it=%0d got lo=%b hi=%b sel=%b", it, obs_be_lo, obs_be_hi, ts);
            end
            if (tw && !oor) ref_write(ts, ta, td);
            if (!tw && !oor) begin
                total++;
                if (obs_rdata !== exp_rd) begin
                    bad++; $display("FAIL rnd_read it=%0d adr=%h sel=%b got=%h want=%h", it, ta, ts, obs_rdata, exp_rd);
                end
                last_rd = exp_rd; known = 1'b1;
            end else if (!tw) begin
                known = 1'b0;
            end else if (known) begin
                total++;
                if (obs_rdata !== last_rd) begin
                    bad++; $display("FAIL rnd_rd_hold it=%0d got=%h want=%h", it, obs_rdata, last_rd);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_word();
        test_read_word();
        test_byte_write();
        test_err_and_empty();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
